// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount as a greedy, largest-first sequence of four denominations over valid/ack.
// Define CHANGE_INVENTORY_EN to add per-denomination stock counters with stock0..stock3 and low_stock outputs.
module change_dispenser #(
    parameter int unsigned DENOM3 = 20,
    parameter int unsigned DENOM2 = 10,
    parameter int unsigned DENOM1 = 5,
    parameter int unsigned DENOM0 = 1
`ifdef CHANGE_INVENTORY_EN
    ,
    parameter int unsigned INIT_STOCK = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] change_in,
    input  logic        coin_ack,
    output logic        coin_valid,
    output logic [1:0]  coin_type,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] remaining,
    output logic [31:0] paid_total
`ifdef CHANGE_INVENTORY_EN
    ,
    output logic [15:0] stock0,
    output logic [15:0] stock1,
    output logic [15:0] stock2,
    output logic [15:0] stock3,
    output logic        low_stock
`endif
);
    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [3:0] fit;
    logic [1:0] pick;
    logic [31:0] den;
    logic ack;
    assign ack = state == ISSUE && coin_ack;
    assign den = coin_type == 2'd3 ? DENOM3 : coin_type == 2'd2 ? DENOM2 : coin_type == 2'd1 ? DENOM1 : DENOM0;
`ifdef CHANGE_INVENTORY_EN
    logic [15:0] stock [4];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stock <= '{default: 16'(INIT_STOCK)};
        else if (ack) stock[coin_type] <= stock[coin_type] - 16'd1;
    assign {stock3, stock2, stock1, stock0} = {stock[3], stock[2], stock[1], stock[0]};
    assign low_stock = stock[0] < 16'd2 || stock[1] < 16'd2 || stock[2] < 16'd2 || stock[3] < 16'd2;
`endif
    // A denomination fits when it does not overshoot what is owed (and, with inventory, is in stock)
    always_comb begin
        fit = {remaining >= DENOM3, remaining >= DENOM2, remaining >= DENOM1, remaining >= DENOM0};
`ifdef CHANGE_INVENTORY_EN
        fit = fit & {stock[3] != 16'd0, stock[2] != 16'd0, stock[1] != 16'd0, stock[0] != 16'd0};
`endif
        pick = fit[3] ? 2'd3 : fit[2] ? 2'd2 : fit[1] ? 2'd1 : 2'd0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = change_in[31] ? ERR : SELECT;
            SELECT:  state_nx = remaining == '0 ? DONE : |fit ? ISSUE : ERR;
            ISSUE:   if (coin_ack) state_nx = SELECT;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        coin_valid = state == ISSUE;
        busy = state != IDLE;
        done = state == DONE;
        err = state == ERR;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            remaining <= '0;
            paid_total <= '0;
            coin_type <= '0;
        end else if (state == IDLE && start) begin
            remaining <= change_in[31] ? '0 : change_in;
            paid_total <= '0;
        end else if (state == SELECT && remaining != '0 && |fit) begin
            coin_type <= pick;
        end else if (ack) begin
            remaining <= remaining - den;
            paid_total <= paid_total + den;
        end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized requests checked against a greedy arithmetic payout model.
module tb_change_dispenser;
    logic clk = 0, rst_n = 0, start = 0, coin_ack = 0;
    logic [31:0] change_in = '0;
    logic coin_valid, busy, done, err;
    logic [1:0] coin_type;
    logic [31:0] remaining, paid_total;
    int passed = 0, total = 0;

    change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .start(start), .change_in(change_in), .coin_ack(coin_ack),
        .coin_valid(coin_valid), .coin_type(coin_type), .busy(busy), .done(done), .err(err),
        .remaining(remaining), .paid_total(paid_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs are driven and outputs sampled on the falling edge; the DUT acts on rising edges.
    task automatic run_req(input logic [31:0] amt, input int hold);
        int q[$];
        logic [31:0] r;
        int t;
        r = amt;
        if (!amt[31]) begin
            while (r >= 20) begin q.push_back(3); r -= 20; end
            while (r >= 10) begin q.push_back(2); r -= 10; end
            while (r >= 5)  begin q.push_back(1); r -= 5;  end
            while (r >= 1)  begin q.push_back(0); r -= 1;  end
        end
        start = 1;
        change_in = amt;
        @(negedge clk);
        start = 0;
        if (amt[31]) begin
            chk(err, 1, "underpay_err");
            chk(coin_valid, 0, "underpay_valid");
            chk(remaining, 0, "underpay_remaining");
            @(negedge clk);
            chk(err, 0, "err_pulse_width");
            chk(busy, 0, "err_idle");
            return;
        end
        chk(coin_valid, 0, "select_gap");
        chk(remaining, amt, "latched_amount");
        chk(paid_total, 0, "paid_cleared");
        @(negedge clk);
        while (q.size() > 0) begin
            t = q.pop_front();
            chk(coin_valid, 1, "coin_valid");
            chk(32'(coin_type), 32'(t), "coin_type");
            chk(paid_total + remaining, amt, "invariant");
            chk(err, 0, "no_err");
            for (int i = 0; i < hold; i++) begin
                start = i[0];
                change_in = 32'd99;
                @(negedge clk);
                chk(coin_valid, 1, "hold_valid");
                chk(32'(coin_type), 32'(t), "hold_type");
            end
            start = 0;
            coin_ack = 1;
            @(negedge clk);
            coin_ack = 0;
            chk(coin_valid, 0, "post_ack_gap");
            @(negedge clk);
        end
        chk(done, 1, "done");
        chk(err, 0, "done_no_err");
        chk(paid_total, amt, "paid_total");
        chk(remaining, 0, "remaining_zero");
        @(negedge clk);
        chk(done, 0, "done_pulse_width");
        chk(busy, 0, "back_to_idle");
    endtask

    initial begin
        logic [31:0] amt;
        repeat (2) @(negedge clk);
        chk(coin_valid, 0, "rst_valid");
        chk(busy, 0, "rst_busy");
        chk(32'(coin_type), 0, "rst_type");
        chk(remaining, 0, "rst_remaining");
        chk(paid_total, 0, "rst_paid");
        chk({30'd0, done, err}, 0, "rst_done_err");
        rst_n = 1;
        @(negedge clk);
        coin_ack = 1;
        @(negedge clk);
        coin_ack = 0;
        chk(busy, 0, "stray_ack_ignored");
        run_req(32'd37, 1);
        run_req(32'd0, 0);
        run_req(32'h8000_0005, 0);
        run_req(32'd20, 10);
        start = 1;
        change_in = 32'd30;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk(32'(coin_type), 3, "mid_first_type");
        coin_ack = 1;
        @(negedge clk);
        coin_ack = 0;
        chk(remaining, 10, "mid_remaining");
        chk(paid_total, 20, "mid_paid");
        rst_n = 0;
        #1;
        chk(coin_valid, 0, "async_valid");
        chk(remaining, 0, "async_remaining");
        chk(paid_total, 0, "async_paid");
        chk(busy, 0, "async_busy");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_req(32'd6, 0);
        for (int n = 0; n < 25; n++) begin
            amt = $urandom_range(0, 9) == 0 ? (32'h8000_0000 | 32'($urandom_range(0, 50))) : 32'($urandom_range(0, 120));
            run_req(amt, $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
